// File: rtl/div_seq_ctrl.sv
// Sequencing controller for the EXE-stage divider IPs: latches operands, runs the
// AXI-Stream input handshakes, captures quotient/remainder and drains on flush.
module div_seq_ctrl #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req_valid,
  input  logic [1:0]        req_op,
  input  logic [XLEN-1:0]   req_src1,
  input  logic [XLEN-1:0]   req_src2,
  output logic              req_ready,
  input  logic              flush,
  output logic              res_valid,
  output logic [XLEN-1:0]   res_data,
  input  logic              res_ack,
  output logic [XLEN-1:0]   div_dividend_tdata,
  output logic [XLEN-1:0]   div_divisor_tdata,
  output logic              sdiv_dividend_tvalid,
  output logic              sdiv_divisor_tvalid,
  input  logic              sdiv_dividend_tready,
  input  logic              sdiv_divisor_tready,
  input  logic              sdiv_dout_tvalid,
  input  logic [2*XLEN-1:0] sdiv_dout_tdata,
  output logic              udiv_dividend_tvalid,
  output logic              udiv_divisor_tvalid,
  input  logic              udiv_dividend_tready,
  input  logic              udiv_divisor_tready,
  input  logic              udiv_dout_tvalid,
  input  logic [2*XLEN-1:0] udiv_dout_tdata
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SEND  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DONE  = 3'd3,
    ST_DRAIN = 3'd4
  } state_t;

  state_t            state_r;
  logic              is_unsigned_r;
  logic              is_mod_r;
  logic              dvd_sent_r;
  logic              dvs_sent_r;
  logic              flush_pend_r;
  logic              req_ready_r;
  logic              res_valid_r;
  logic [XLEN-1:0]   res_data_r;
  logic [XLEN-1:0]   dividend_r;
  logic [XLEN-1:0]   divisor_r;
  logic              s_dvd_tvalid_r;
  logic              s_dvs_tvalid_r;
  logic              u_dvd_tvalid_r;
  logic              u_dvs_tvalid_r;

  logic              dvd_hs_s;
  logic              dvs_hs_s;
  logic              dvd_done_s;
  logic              dvs_done_s;
  logic              dout_tvalid_s;
  logic [2*XLEN-1:0] dout_tdata_s;
  logic [XLEN-1:0]   dout_sel_s;

  // Only the IP picked by the latched signedness is ever looked at; the other is ignored.
  assign dvd_hs_s      = is_unsigned_r ? (u_dvd_tvalid_r & udiv_dividend_tready)
                                       : (s_dvd_tvalid_r & sdiv_dividend_tready);
  assign dvs_hs_s      = is_unsigned_r ? (u_dvs_tvalid_r & udiv_divisor_tready)
                                       : (s_dvs_tvalid_r & sdiv_divisor_tready);
  assign dvd_done_s    = dvd_sent_r | dvd_hs_s;
  assign dvs_done_s    = dvs_sent_r | dvs_hs_s;
  assign dout_tvalid_s = is_unsigned_r ? udiv_dout_tvalid : sdiv_dout_tvalid;
  assign dout_tdata_s  = is_unsigned_r ? udiv_dout_tdata : sdiv_dout_tdata;
  assign dout_sel_s    = is_mod_r ? dout_tdata_s[XLEN-1:0] : dout_tdata_s[2*XLEN-1:XLEN];

  // Controller FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r        <= ST_IDLE;
      is_unsigned_r  <= 1'b0;
      is_mod_r       <= 1'b0;
      dvd_sent_r     <= 1'b0;
      dvs_sent_r     <= 1'b0;
      flush_pend_r   <= 1'b0;
      req_ready_r    <= 1'b1;
      res_valid_r    <= 1'b0;
      res_data_r     <= {XLEN{1'b0}};
      dividend_r     <= {XLEN{1'b0}};
      divisor_r      <= {XLEN{1'b0}};
      s_dvd_tvalid_r <= 1'b0;
      s_dvs_tvalid_r <= 1'b0;
      u_dvd_tvalid_r <= 1'b0;
      u_dvs_tvalid_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (req_valid && !flush) begin
            dividend_r     <= req_src1;
            divisor_r      <= req_src2;
            is_unsigned_r  <= req_op[1];
            is_mod_r       <= req_op[0];
            dvd_sent_r     <= 1'b0;
            dvs_sent_r     <= 1'b0;
            flush_pend_r   <= 1'b0;
            s_dvd_tvalid_r <= ~req_op[1];
            s_dvs_tvalid_r <= ~req_op[1];
            u_dvd_tvalid_r <= req_op[1];
            u_dvs_tvalid_r <= req_op[1];
            req_ready_r    <= 1'b0;
            state_r        <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (dvd_hs_s) begin
            dvd_sent_r     <= 1'b1;
            s_dvd_tvalid_r <= 1'b0;
            u_dvd_tvalid_r <= 1'b0;
          end
          if (dvs_hs_s) begin
            dvs_sent_r     <= 1'b1;
            s_dvs_tvalid_r <= 1'b0;
            u_dvs_tvalid_r <= 1'b0;
          end
          // tvalid is never retracted: a flush here only diverts the finished send to DRAIN.
          if (dvd_done_s && dvs_done_s) begin
            flush_pend_r <= 1'b0;
            state_r      <= (flush_pend_r || flush) ? ST_DRAIN : ST_WAIT;
          end else if (flush) begin
            flush_pend_r <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (dout_tvalid_s) begin
            if (flush) begin
              req_ready_r <= 1'b1;
              state_r     <= ST_IDLE;
            end else begin
              res_data_r  <= dout_sel_s;
              res_valid_r <= 1'b1;
              state_r     <= ST_DONE;
            end
          end else if (flush) begin
            state_r <= ST_DRAIN;
          end
        end
        ST_DONE: begin
          if (flush || res_ack) begin
            res_valid_r <= 1'b0;
            req_ready_r <= 1'b1;
            state_r     <= ST_IDLE;
          end
        end
        ST_DRAIN: begin
          if (dout_tvalid_s) begin
            req_ready_r <= 1'b1;
            state_r     <= ST_IDLE;
          end
        end
        default: begin
          s_dvd_tvalid_r <= 1'b0;
          s_dvs_tvalid_r <= 1'b0;
          u_dvd_tvalid_r <= 1'b0;
          u_dvs_tvalid_r <= 1'b0;
          flush_pend_r   <= 1'b0;
          res_valid_r    <= 1'b0;
          req_ready_r    <= 1'b1;
          state_r        <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready            = req_ready_r;
  assign res_valid            = res_valid_r;
  assign res_data             = res_data_r;
  assign div_dividend_tdata   = dividend_r;
  assign div_divisor_tdata    = divisor_r;
  assign sdiv_dividend_tvalid = s_dvd_tvalid_r;
  assign sdiv_divisor_tvalid  = s_dvs_tvalid_r;
  assign udiv_dividend_tvalid = u_dvd_tvalid_r;
  assign udiv_divisor_tvalid  = u_dvs_tvalid_r;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Bench for div_seq_ctrl: behavioural divider IPs with programmable tready delay and
// latency, directed flush/reset scenarios and randomized divides against arithmetic.
module tb_div_seq_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req_valid;
  logic [1:0]  req_op;
  logic [31:0] req_src1;
  logic [31:0] req_src2;
  logic        flush;
  logic        res_ack;
  wire         req_ready;
  wire         res_valid;
  wire  [31:0] res_data;
  wire  [31:0] dvd_td;
  wire  [31:0] dvs_td;
  wire         s_dvd_tv, s_dvs_tv, u_dvd_tv, u_dvs_tv;

  // Index 0 = signed IP, index 1 = unsigned IP.
  logic [1:0]  ip_dvd_rdy, ip_dvs_rdy, ip_dout_tv;
  logic [63:0] ip_dout [2];
  logic [1:0]  ip_dvd_tv, ip_dvs_tv, a_hs, b_hs;
  logic [1:0]  got_dvd, got_dvs, busy;
  logic [31:0] lat_a [2];
  logic [31:0] lat_b [2];
  logic [63:0] pend [2];
  int          hc_dvd [2];
  int          hc_dvs [2];
  int          cnt [2];
  int          dvd_delay, dvs_delay, ip_lat;
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  div_seq_ctrl #(.XLEN(32)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_op(req_op), .req_src1(req_src1), .req_src2(req_src2),
    .req_ready(req_ready), .flush(flush),
    .res_valid(res_valid), .res_data(res_data), .res_ack(res_ack),
    .div_dividend_tdata(dvd_td), .div_divisor_tdata(dvs_td),
    .sdiv_dividend_tvalid(s_dvd_tv), .sdiv_divisor_tvalid(s_dvs_tv),
    .sdiv_dividend_tready(ip_dvd_rdy[0]), .sdiv_divisor_tready(ip_dvs_rdy[0]),
    .sdiv_dout_tvalid(ip_dout_tv[0]), .sdiv_dout_tdata(ip_dout[0]),
    .udiv_dividend_tvalid(u_dvd_tv), .udiv_divisor_tvalid(u_dvs_tv),
    .udiv_dividend_tready(ip_dvd_rdy[1]), .udiv_divisor_tready(ip_dvs_rdy[1]),
    .udiv_dout_tvalid(ip_dout_tv[1]), .udiv_dout_tdata(ip_dout[1])
  );

  assign ip_dvd_tv = {u_dvd_tv, s_dvd_tv};
  assign ip_dvs_tv = {u_dvs_tv, s_dvs_tv};
  assign a_hs      = ip_dvd_tv & ip_dvd_rdy;
  assign b_hs      = ip_dvs_tv & ip_dvs_rdy;

  // Divider IP output {quotient, remainder}; x/0 gives all-ones quotient and the dividend as remainder.
  function automatic logic [63:0] ip_result(input bit uns, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    logic [31:0] q, r;
    if (b == 32'd0) return {32'hFFFF_FFFF, a};
    if (uns) return {a / b, a % b};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h8000_0000, 32'd0};
    sa = a;
    sb = b;
    q  = sa / sb;
    r  = sa % sb;
    return {q, r};
  endfunction

  function automatic logic [31:0] exp_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] full;
    full = ip_result(op[1], a, b);
    return op[0] ? full[31:0] : full[63:32];
  endfunction

  // Behavioural IPs: tready after a programmed number of tvalid cycles, result ip_lat cycles after input.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      ip_dout_tv[i] <= 1'b0;
      if (!resetn) begin
        got_dvd[i]    <= 1'b0;
        got_dvs[i]    <= 1'b0;
        busy[i]       <= 1'b0;
        hc_dvd[i]     <= 0;
        hc_dvs[i]     <= 0;
        cnt[i]        <= 0;
        ip_dout[i]    <= 64'd0;
        ip_dvd_rdy[i] <= (dvd_delay == 0);
        ip_dvs_rdy[i] <= (dvs_delay == 0);
      end else begin
        if (a_hs[i]) begin
          got_dvd[i] <= 1'b1; lat_a[i] <= dvd_td; hc_dvd[i] <= 0; ip_dvd_rdy[i] <= (dvd_delay == 0);
        end else if (ip_dvd_tv[i]) begin
          hc_dvd[i] <= hc_dvd[i] + 1; ip_dvd_rdy[i] <= (hc_dvd[i] + 1 >= dvd_delay);
        end else begin
          hc_dvd[i] <= 0; ip_dvd_rdy[i] <= (dvd_delay == 0);
        end
        if (b_hs[i]) begin
          got_dvs[i] <= 1'b1; lat_b[i] <= dvs_td; hc_dvs[i] <= 0; ip_dvs_rdy[i] <= (dvs_delay == 0);
        end else if (ip_dvs_tv[i]) begin
          hc_dvs[i] <= hc_dvs[i] + 1; ip_dvs_rdy[i] <= (hc_dvs[i] + 1 >= dvs_delay);
        end else begin
          hc_dvs[i] <= 0; ip_dvs_rdy[i] <= (dvs_delay == 0);
        end
        if ((got_dvd[i] | a_hs[i]) && (got_dvs[i] | b_hs[i])) begin
          got_dvd[i] <= 1'b0;
          got_dvs[i] <= 1'b0;
          busy[i]    <= 1'b1;
          cnt[i]     <= ip_lat - 1;
          pend[i]    <= ip_result(i == 1, got_dvd[i] ? lat_a[i] : dvd_td, got_dvs[i] ? lat_b[i] : dvs_td);
        end else if (busy[i]) begin
          if (cnt[i] <= 1) begin
            busy[i] <= 1'b0; ip_dout_tv[i] <= 1'b1; ip_dout[i] <= pend[i];
          end else begin
            cnt[i] <= cnt[i] - 1;
          end
        end
      end
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_req_ready"}, req_ready, 1);
    check_eq({tag, "_res_valid"}, res_valid, 0);
    check_eq({tag, "_tvalids"}, {s_dvd_tv, s_dvs_tv, u_dvd_tv, u_dvs_tv}, 0);
  endtask

  task automatic issue_req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           input int d1, input int d2, input int lat);
    dvd_delay = d1;
    dvs_delay = d2;
    ip_lat    = lat;
    check_eq("req_ready_idle", req_ready, 1);
    req_valid = 1'b1;
    req_op    = op;
    req_src1  = a;
    req_src2  = b;
  endtask

  // Cycle k counts cycles after the accepting edge; res_valid is due at 2 + max(delays) + latency.
  task automatic expect_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                               input int d1, input int d2, input int lat);
    int  exp_k;
    bit  uns;
    uns   = op[1];
    exp_k = 2 + ((d1 > d2) ? d1 : d2) + lat;
    for (int k = 1; k <= exp_k; k++) begin
      @(posedge clk); #1;
      check_eq("sdiv_dividend_tvalid", s_dvd_tv, !uns && k <= 1 + d1);
      check_eq("sdiv_divisor_tvalid",  s_dvs_tv, !uns && k <= 1 + d2);
      check_eq("udiv_dividend_tvalid", u_dvd_tv, uns && k <= 1 + d1);
      check_eq("udiv_divisor_tvalid",  u_dvs_tv, uns && k <= 1 + d2);
      check_eq("res_valid_timing", res_valid, k == exp_k);
      check_eq("req_ready_busy", req_ready, 0);
      if (k == 1) begin
        check_eq("dividend_tdata", dvd_td, a);
        check_eq("divisor_tdata", dvs_td, b);
      end
    end
    check_eq("res_data", res_data, exp_result(op, a, b));
  endtask

  task automatic ack_result(input logic [31:0] exp, input int hold);
    for (int h = 1; h <= hold; h++) begin
      @(posedge clk); #1;
      check_eq("res_valid_hold", res_valid, 1);
      check_eq("res_data_hold", res_data, exp);
    end
    res_ack = 1'b1;
    @(posedge clk); #1;
    res_ack   = 1'b0;
    req_valid = 1'b0;
    check_eq("res_valid_after_ack", res_valid, 0);
    check_eq("req_ready_after_ack", req_ready, 1);
  endtask

  task automatic run_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int d1, input int d2, input int lat, input int hold);
    issue_req(op, a, b, d1, d2, lat);
    expect_result(op, a, b, d1, d2, lat);
    ack_result(exp_result(op, a, b), hold);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got no finish expected finish");
    $fatal(1);
  end

  initial begin
    bit found;
    resetn = 1'b0; req_valid = 1'b0; req_op = 2'd0; req_src1 = 32'd0; req_src2 = 32'd0;
    flush = 1'b0; res_ack = 1'b0; dvd_delay = 0; dvs_delay = 0; ip_lat = 6;
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    check_eq("reset_res_data", res_data, 0);
    check_eq("reset_tdata", {dvd_td, dvs_td}, 0);
    resetn = 1'b1;
    @(posedge clk); #1;

    // Signed path, L=6, treadys always high; second one back-to-back.
    run_div(2'b00, 32'hFFFF_FFF9, 32'd2, 0, 0, 6, 0);
    run_div(2'b01, 32'hFFFF_FFF9, 32'd2, 0, 0, 6, 0);
    // Unsigned path with split handshake.
    run_div(2'b10, 32'd100, 32'd7, 1, 4, 6, 0);
    run_div(2'b11, 32'd100, 32'd7, 1, 4, 6, 0);
    // res_ack held low for 5 DONE cycles.
    run_div(2'b00, 32'd1000, 32'd3, 0, 0, 3, 5);

    // Flush in SEND after the dividend is taken: divisor still completes, DRAIN swallows dout.
    issue_req(2'b10, 32'd100, 32'd7, 0, 3, 5);
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      flush = (k == 2);
      if (k == 2) req_valid = 1'b0;
      check_eq("send_flush_udvd_tv", u_dvd_tv, k <= 1);
      check_eq("send_flush_udvs_tv", u_dvs_tv, k <= 4);
      check_eq("send_flush_sdiv_tv", {s_dvd_tv, s_dvs_tv}, 0);
      check_eq("send_flush_res_valid", res_valid, 0);
      check_eq("send_flush_req_ready", req_ready, k >= 10);
    end
    flush = 1'b0;
    run_div(2'b10, 32'd9, 32'd3, 0, 0, 6, 0);

    // Flush in WAIT on the same cycle as dout_tvalid.
    issue_req(2'b00, 32'd50, 32'd5, 0, 0, 4);
    found = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      check_eq("wait_flush_res_valid_pre", res_valid, 0);
      if (ip_dout_tv[0]) begin
        found = 1'b1; flush = 1'b1; req_valid = 1'b0;
        break;
      end
    end
    check_eq("wait_flush_dout_seen", found, 1);
    @(posedge clk); #1;
    flush = 1'b0;
    check_idle_outputs("wait_flush");
    @(posedge clk); #1;
    check_idle_outputs("wait_flush_next");

    // Flush and res_ack together in DONE.
    issue_req(2'b01, 32'd50, 32'd7, 0, 0, 3);
    expect_result(2'b01, 32'd50, 32'd7, 0, 0, 3);
    flush = 1'b1; res_ack = 1'b1; req_valid = 1'b0;
    @(posedge clk); #1;
    flush = 1'b0; res_ack = 1'b0;
    check_idle_outputs("done_flush_ack");
    @(posedge clk); #1;
    check_idle_outputs("done_flush_ack_next");

    // Flush in IDLE blocks acceptance.
    req_valid = 1'b1; req_op = 2'b00; req_src1 = 32'd9; req_src2 = 32'd3; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; req_valid = 1'b0;
    check_idle_outputs("idle_flush_block");
    @(posedge clk); #1;
    check_idle_outputs("idle_flush_block_next");

    // Randomized divides, including small values and divide-by-zero.
    for (int t = 0; t < 24; t++) begin
      logic [31:0] ra, rb;
      ra = (t % 4 == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
      run_div(2'($urandom_range(0, 3)), ra, rb, $urandom_range(0, 4), $urandom_range(0, 4),
              $urandom_range(2, 8), $urandom_range(0, 3));
    end

    // Reset during WAIT, then the signed-overflow divide.
    issue_req(2'b00, 32'd100, 32'd7, 0, 0, 6);
    repeat (3) begin
      @(posedge clk); #1;
    end
    resetn = 1'b0; req_valid = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    check_idle_outputs("wait_reset");
    check_eq("wait_reset_res_data", res_data, 0);
    check_eq("wait_reset_tdata", {dvd_td, dvs_td}, 0);
    run_div(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 6, 0);
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      check_eq("post_reset_quiet", res_valid, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
